// File: rtl/ins_cache_if.sv
// ins_cache_if: CPU-side fetch port and instruction-memory block-read port of ins_cache
//   address      PC byte address             (master -> cache)
//   instruction  instruction word            (cache -> master)
//   busywait     stall request to PC/control (cache -> master)
//   mem_read     block-read request          (cache -> memory)
//   mem_address  block address               (cache -> memory)
//   mem_readdata 128-bit block, word 0 low   (memory -> cache)
//   mem_busywait instruction memory busy     (memory -> cache)
interface ins_cache_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] address;
    logic [31:0]       instruction;
    logic              busywait;
    logic              mem_read;
    logic [ADDR_W-5:0] mem_address;
    logic [127:0]      mem_readdata;
    logic              mem_busywait;
    modport slave (
        input  address, mem_readdata, mem_busywait,
        output instruction, busywait, mem_read, mem_address
    );
    modport master (
        output address, mem_readdata, mem_busywait,
        input  instruction, busywait, mem_read, mem_address
    );
endinterface

// File: rtl/ins_cache.sv
// ins_cache: direct-mapped read-only instruction cache, 4-word blocks, blocking memory fill
//   clk        clock, all state changes on rising edge
//   reset_n    asynchronous active-low reset
//   bus        ins_cache_if.slave (CPU fetch port + instruction memory port)
//   hit_count  saturating hit counter   (only with ICACHE_STATS_EN defined)
//   miss_count saturating miss counter  (only with ICACHE_STATS_EN defined)
module ins_cache #(
    parameter int ADDR_W  = 10,
    parameter int INDEX_W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    ins_cache_if.slave   bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);
    localparam int TAG_W = ADDR_W - INDEX_W - 4;
    localparam int NB    = 2 ** INDEX_W;

    typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

    state_t              r_state, w_next;
    logic [NB-1:0]       r_valid;
    logic [TAG_W-1:0]    r_tag  [NB];
    logic [127:0]        r_data [NB];
    logic [ADDR_W-5:0]   r_mem_addr;
    logic                r_seen_busy;
    logic [INDEX_W-1:0]  w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_hit, w_busy, w_mem_read;
    logic                w_unused;

    assign w_idx    = bus.address[INDEX_W+3:4];
    assign w_tag    = bus.address[ADDR_W-1:INDEX_W+4];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_unused = &{1'b0, bus.address[1:0]};

    // Outputs are forced quiet while reset is held, even though all blocks are invalid.
    assign bus.instruction = reset_n ? r_data[w_idx][{bus.address[3:2], 5'b0} +: 32] : 32'h0;
    assign bus.busywait    = reset_n & w_busy;
    assign bus.mem_read    = w_mem_read;
    assign bus.mem_address = r_mem_addr;

    always_comb begin
        w_next     = r_state;
        w_busy     = 1'b0;
        w_mem_read = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_busy = !w_hit;
                w_next = w_hit ? IDLE : MEM_READ;
            end
            MEM_READ: begin
                w_busy     = 1'b1;
                w_mem_read = 1'b1;
                // Completion needs a busy cycle first, so a stale low busywait is not taken as done.
                w_next     = (!bus.mem_busywait && r_seen_busy) ? UPDATE : MEM_READ;
            end
            UPDATE: begin
                w_busy = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_mem_addr  <= '0;
            r_seen_busy <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && !w_hit) begin
                r_mem_addr  <= bus.address[ADDR_W-1:4];
                r_seen_busy <= 1'b0;
            end
            if (r_state == MEM_READ && bus.mem_busywait)
                r_seen_busy <= 1'b1;
            if (r_state == UPDATE)
                r_valid[r_mem_addr[INDEX_W-1:0]] <= 1'b1;
        end
    end

    // Tag and data are filled from the latched block address, so address changes mid-fill are ignored.
    always_ff @(posedge clk) begin
        if (r_state == UPDATE) begin
            r_data[r_mem_addr[INDEX_W-1:0]] <= bus.mem_readdata;
            r_tag[r_mem_addr[INDEX_W-1:0]]  <= r_mem_addr[ADDR_W-5:INDEX_W];
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] r_hit_cnt, r_miss_cnt;

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (r_state == IDLE && w_hit && r_hit_cnt != 16'hFFFF)
                r_hit_cnt <= r_hit_cnt + 16'd1;
            if (r_state == IDLE && !w_hit && r_miss_cnt != 16'hFFFF)
                r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ins_cache.sv
// tb_ins_cache: self-checking bench for ins_cache with a behavioural instruction memory
module tb_ins_cache;
    localparam int ADDR_W  = 10;
    localparam int INDEX_W = 3;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       instr;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   lat = 5;
    int   cnt = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    ins_cache_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    ins_cache #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // Memory: busy for lat cycles after mem_read rises; word w of block b reads {b, w}.
    always @(negedge clk) begin
        if (!bus.mem_read) begin
            bus.mem_busywait = 1'b0;
            cnt = 0;
        end else if (cnt < lat) begin
            bus.mem_busywait = 1'b1;
            cnt++;
        end else begin
            bus.mem_busywait = 1'b0;
        end
        for (int w = 0; w < 4; w++)
            bus.mem_readdata[32*w +: 32] = {16'(bus.mem_address), 16'(w)};
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_miss(input string nm, input logic [ADDR_W-1:0] a, input logic [5:0] blk,
                           input int edges, input logic [31:0] instr);
        int n = 0;
        bit saw = 1'b0;
        bus.address = a;
        #1;
        check({nm, " busy at miss"}, bus.busywait, 1);
        while (bus.busywait && n < 60) begin
            tick();
            n++;
            if (bus.mem_read) saw = 1'b1;
        end
        check({nm, " edges"}, n, edges);
        check({nm, " mem_read seen"}, saw, 1);
        check({nm, " mem_address"}, bus.mem_address, blk);
        check({nm, " instruction"}, bus.instruction, instr);
        check({nm, " busy after"}, bus.busywait, 0);
    endtask

    vec_t tbl[6];

    initial begin
        int n;
        tbl[0] = '{10'h000, 32'h0000_0000};
        tbl[1] = '{10'h004, 32'h0000_0001};
        tbl[2] = '{10'h008, 32'h0000_0002};
        tbl[3] = '{10'h00C, 32'h0000_0003};
        tbl[4] = '{10'h001, 32'h0000_0000};
        tbl[5] = '{10'h00E, 32'h0000_0003};

        bus.address = '0;
        tick();
        tick();
        check("rst busywait", bus.busywait, 0);
        check("rst mem_read", bus.mem_read, 0);
        check("rst instruction", bus.instruction, 0);
        check("rst mem_address", bus.mem_address, 0);
        reset_n = 1'b1;
        #1;
        check("cold miss busy", bus.busywait, 1);

        do_miss("fill0", 10'h000, 6'h00, 8, 32'h0000_0000);

        foreach (tbl[i]) begin
            bus.address = tbl[i].a;
            #1;
            check($sformatf("hit[%0d] instr", i), bus.instruction, tbl[i].instr);
            check($sformatf("hit[%0d] busy", i), bus.busywait, 0);
            check($sformatf("hit[%0d] mem_read", i), bus.mem_read, 0);
        end

        do_miss("fill10", 10'h010, 6'h01, 8, 32'h0001_0000);
        do_miss("conflict90", 10'h090, 6'h09, 8, 32'h0009_0000);
        do_miss("refill10", 10'h010, 6'h01, 8, 32'h0001_0000);
        bus.address = 10'h000;
        #1;
        check("blk0 kept busy", bus.busywait, 0);

        bus.address = 10'h020;
        tick();
        check("mid mem_read", bus.mem_read, 1);
        check("mid mem_address", bus.mem_address, 6'h02);
        bus.address = 10'h040;
        n = 0;
        while (bus.mem_read && n < 60) begin
            tick();
            n++;
        end
        check("mid read edges", n, 6);
        check("mid update busy", bus.busywait, 1);
        tick();
        check("mid second miss busy", bus.busywait, 1);
        check("mid second miss idle", bus.mem_read, 0);
        tick();
        check("mid second mem_read", bus.mem_read, 1);
        check("mid second mem_address", bus.mem_address, 6'h04);
        n = 0;
        while (bus.busywait && n < 60) begin
            tick();
            n++;
        end
        check("mid second edges", n, 7);
        check("mid 0x040 instr", bus.instruction, 32'h0004_0000);
        bus.address = 10'h020;
        #1;
        check("mid 0x020 instr", bus.instruction, 32'h0002_0000);
        check("mid 0x020 busy", bus.busywait, 0);

        bus.address = 10'h030;
        tick();
        tick();
        check("rstfill mem_read", bus.mem_read, 1);
        reset_n = 1'b0;
        #1;
        check("rstfill mem_read drop", bus.mem_read, 0);
        check("rstfill busy drop", bus.busywait, 0);
        check("rstfill instruction", bus.instruction, 0);
        tick();
        reset_n = 1'b1;
        bus.address = 10'h000;
        #1;
        check("post-rst miss busy", bus.busywait, 1);
        do_miss("post-rst fill0", 10'h000, 6'h00, 8, 32'h0000_0000);
`ifdef ICACHE_STATS_EN
        check("stats miss", miss_count, 1);
        check("stats hit0", hit_count, 0);
        tick();
        tick();
        tick();
        check("stats hit3", hit_count, 3);
        check("stats miss1", miss_count, 1);
`endif

        lat = 1;
        do_miss("wrap", 10'h3FC, 6'h3F, 4, 32'h003F_0003);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ins_cache.md
# ins_cache

Direct-mapped, read-only instruction cache between the PC and the instruction memory, directly upstream of the instruction decoder/control unit. Returns the 32-bit instruction for the current PC, stalling the CPU via `busywait` on a miss. On a miss it fetches a 16-byte block from instruction memory using a blocking read handshake.

## Interface
- `ADDR_W`, 10: PC byte-address width.
- `INDEX_W`, 3: index width; `2**INDEX_W` blocks of 4 words; tag width = `ADDR_W-INDEX_W-4`.

- `clk`  in  1  clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  ADDR_W  PC byte address; `[1:0]` ignored, `[3:2]` word offset, `[INDEX_W+3:4]` index, upper bits tag.
- `instruction`  out  32  instruction word for `address`; valid when `busywait`=0.
- `busywait`  out  1  stall request to PC/control unit.
- `mem_read`  out  1  block-read request to instruction memory.
- `mem_address`  out  ADDR_W-4  block address (`address[ADDR_W-1:4]` latched at miss).
- `mem_readdata`  in  128  fetched block; word 0 in `[31:0]`.
- `mem_busywait`  in  1  instruction memory busy.

## Operation
- Storage per block: valid bit, tag, 128-bit data. Reset clears all valid bits; tag/data not reset.
- Hit = `valid[index] && tag[index]==address tag`. On hit, `instruction` = selected word, combinational from `address`.
- FSM states: IDLE, MEM_READ, UPDATE.
  - IDLE: `busywait` = !hit. On miss, latch block address into `mem_address`, go MEM_READ.
  - MEM_READ: `mem_read`=1, `busywait`=1. Leave on first rising edge where `mem_busywait`=0 **and** `mem_busywait` has been sampled 1 at least once in this state; go UPDATE.
  - UPDATE: `busywait`=1, `mem_read`=0. At the edge: write `mem_readdata` into the block, set tag and valid, return to IDLE.
- Next cycle in IDLE the same address hits; `busywait` drops combinationally.
- `address` changes during MEM_READ/UPDATE are ignored; the fill completes for the latched block, then IDLE re-evaluates the new address.
- Reset values: state IDLE, `mem_read`=0, `busywait`=0, `mem_address`=0, `instruction`=0 while `reset_n`=0.

## Timing
- Hit latency: 0 cycles (combinational read).
- Miss penalty: 1 (IDLE→MEM_READ) + N memory-busy cycles + 1 (completion) + 1 (UPDATE) edges, then hit.
- `mem_read` is held high continuously through MEM_READ; it never pulses.
- Reset asserted mid-fill: `mem_read` and `busywait` drop immediately (asynchronous); FSM to IDLE; partial block discarded; all blocks invalid.
- Index wrap: address `ADDR_W`-max maps to index `2**INDEX_W-1`; no special handling.
- Conflict miss: new tag on a valid index overwrites the block; no write-back (read-only).

## Configuration
- `ICACHE_STATS_EN`: when defined, adds outputs `hit_count` (16) and `miss_count` (16). `hit_count` increments on each rising edge in IDLE with hit and `reset_n`=1; `miss_count` increments on each IDLE→MEM_READ transition. Both saturate at 16'hFFFF and reset to 0. When undefined, the ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- Reset, `address`=0x000, memory busy 5 cycles, returns 128'h…0003_0002_0001_0000 → `busywait` high until UPDATE completes; `mem_address`=0; then `instruction`=0x0000_0000, and with `address`=0x008 `instruction`=0x0000_0002 with `busywait`=0 on the same cycle.
- Sequential fetch 0x000–0x00C after fill → four hits, `mem_read` never asserted.
- Conflict: fill 0x010 (index 1), then access 0x090 (same index, new tag) → miss, `mem_address`=0x09; subsequent 0x010 misses again.
- Change `address` mid-MEM_READ from 0x020 to 0x040 → fill completes for block 0x02, then a second miss fetches block 0x04.
- Assert `reset_n`=0 during MEM_READ → `mem_read`=0, `busywait`=0 immediately; after release, 0x000 misses again.
- With `ICACHE_STATS_EN`: one miss then 3 hit cycles → `miss_count`=1, `hit_count`=3.
